// File: rtl/gups_pkg.sv
// ---------------------------------------------------------------------------
// gups_pkg
// Shared definitions for the GUPS memory-side controller.
//   DATA_W          : memory / generator data width (64)
//   MAX_RD_LAT      : largest supported read latency in cycles (8)
//   LAT_W           : width of the read-latency down-counter
//   gups_mc_state_t : controller FSM state encoding
// ---------------------------------------------------------------------------
package gups_pkg;

  localparam int DATA_W     = 64;
  localparam int MAX_RD_LAT = 8;
  // Counter is loaded with RD_LAT-1, so 0..MAX_RD_LAT-1 must fit.
  localparam int LAT_W      = $clog2(MAX_RD_LAT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RD_RESP  = 3'd3,
    WR_WAIT  = 3'd4,
    WR_ISSUE = 3'd5,
    WR_RESP  = 3'd6
  } gups_mc_state_t;

endpackage

// File: rtl/gups_rd_lat_ctr.sv
// ---------------------------------------------------------------------------
// gups_rd_lat_ctr
// Loadable down-counter that times the fixed memory read latency. It is loaded
// when a read is granted and counts down while the controller waits; zero_o
// marks the cycle in which mem_rdata is valid and must be captured.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset (count -> 0)
//   load_i     : load load_val_i this cycle (takes priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement (holds at zero)
//   zero_o     : count is zero
// ---------------------------------------------------------------------------
module gups_rd_lat_ctr
  import gups_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gups_mem_ctrl.sv
// ---------------------------------------------------------------------------
// gups_mem_ctrl
// Memory-side controller for the GUPS update generator. Serves one
// read-modify-write at a time against a single-port SRAM-style memory with
// grant backpressure and a fixed read latency.
//
// Generator handshake: req is held high for the whole RMW. With write=0 the
// controller reads the word and pulses ready for one cycle with data_in valid;
// the generator then raises write with dout, and the controller writes the word
// and pulses ready again. The generator drops req after the second pulse.
// Memory handshake: an access is taken on a cycle where mem_en=1 and
// mem_gnt=1; until then mem_en/mem_we/mem_addr/mem_wdata stay unchanged.
//
// Parameters: AW (word-address width), RD_LAT (read latency, 1..8)
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   req, write, address,
//   dout                 : generator request, phase, byte address, write data
//   ready, data_in       : completion pulse, read data (held until next read)
//   mem_en, mem_we,
//   mem_addr, mem_wdata  : registered memory request
//   mem_gnt, mem_rdata   : memory grant, read data
//   addr_err             : sticky out-of-range / misaligned address flag
//   upd_count            : completed RMW count
//   dbg_state            : current FSM state
// Build option: GUPS_STATS_EN enables the saturating upd_count counter;
// otherwise upd_count is constant zero.
// ---------------------------------------------------------------------------
module gups_mem_ctrl
  import gups_pkg::*;
#(
  parameter int AW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] dout,
  output logic              ready,
  output logic [DATA_W-1:0] data_in,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err,
  output logic [31:0]       upd_count,
  output gups_mc_state_t    dbg_state
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  gups_mc_state_t    state_q;
  logic              ready_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] data_in_q;
  logic              addr_err_q;

  logic addr_bad;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  // Bits above the word index or inside the 8-byte word are not addressable.
  assign addr_bad = (|address[DATA_W-1:AW+3]) | (|address[2:0]);

  assign cnt_load = (state_q == RD_ISSUE) && mem_gnt;
  assign cnt_dec  = (state_q == RD_WAIT);

  gups_rd_lat_ctr u_rd_lat_ctr (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (LAT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // ready is registered: it is set on the edge entering RD_RESP/WR_RESP, so
  // it is high exactly while the FSM sits in one of those states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      data_in_q   <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A write phase seen here has no preceding read; ignore it.
          if (req && !write) begin
            mem_addr_q <= address[AW+2:3];
            if (addr_bad) addr_err_q <= 1'b1;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            state_q    <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (mem_gnt) begin
            mem_en_q <= 1'b0;
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt_zero) begin
            data_in_q <= mem_rdata;
            ready_q   <= 1'b1;
            state_q   <= RD_RESP;
          end
        end
        RD_RESP: begin
          state_q <= WR_WAIT;
        end
        WR_WAIT: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (write) begin
            mem_wdata_q <= dout;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (mem_gnt) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef GUPS_STATS_EN
  logic [31:0] upd_count_q;
  logic [31:0] upd_count_d;

  // Counts on the write grant, i.e. together with the WR_RESP ready pulse.
  always_comb begin
    upd_count_d = upd_count_q;
    if ((state_q == WR_ISSUE) && mem_gnt && (upd_count_q != 32'hFFFF_FFFF)) begin
      upd_count_d = upd_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_count_q <= '0;
    end else begin
      upd_count_q <= upd_count_d;
    end
  end

  assign upd_count = upd_count_q;
`else
  assign upd_count = '0;
`endif

  assign ready     = ready_q;
  assign data_in   = data_in_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign addr_err  = addr_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gups_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gups_mem_ctrl
// Directed bench for gups_mem_ctrl with a behavioural memory (grant stalls,
// fixed read latency), a data_in scoreboard popped on every ready pulse and a
// write scoreboard popped on every granted memory write.
// ---------------------------------------------------------------------------
module tb_gups_mem_ctrl;
  import gups_pkg::*;

  localparam int AW     = 16;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              write;
  logic [63:0]       address;
  logic [63:0]       dout;
  logic              ready;
  logic [63:0]       data_in;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_gnt;
  logic [63:0]       mem_rdata;
  logic              addr_err;
  logic [31:0]       upd_count;
  gups_mc_state_t    dbg_state;

  always #5 clk = ~clk;

  gups_mem_ctrl #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .write     (write),
    .address   (address),
    .dout      (dout),
    .ready     (ready),
    .data_in   (data_in),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .addr_err  (addr_err),
    .upd_count (upd_count),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0]      exp_q[$];   // data_in expected at each ready pulse
  logic [AW+63:0]   wr_q[$];    // {word addr, data} expected per memory write
  logic [63:0]      mem_model [logic [AW-1:0]];
  logic [63:0]      last_rd = '0;
  logic [31:0]      exp_cnt = '0;
  int               stall_rd = 0;
  int               stall_wr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] next_cnt(input logic [31:0] c);
`ifdef GUPS_STATS_EN
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
`else
    return c;
`endif
  endfunction

  // ---------------- memory model: read pipeline + write monitor ----------------
  logic [63:0] pipe_d [RD_LAT];
  logic        pipe_v [RD_LAT];

  always begin
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_v[i] = 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_v[i] = pipe_v[i-1];
        pipe_d[i] = pipe_d[i-1];
      end
      pipe_v[0] = mem_en && !mem_we && mem_gnt;
      pipe_d[0] = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'd0;
      if (mem_en && mem_we && mem_gnt) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", {mem_addr, mem_wdata}, '0);
        end else begin
          check("mem_write", {mem_addr, mem_wdata}, wr_q.pop_front());
        end
        mem_model[mem_addr] = mem_wdata;
      end
    end
    #1;
    // Read data is driven only in the cycle it is defined valid; junk otherwise.
    mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : {$urandom, $urandom};
  end

  // ---------------- grant model with stall + hold check ----------------
  logic [AW+64:0] snap;
  logic           snap_v = 1'b0;

  always begin
    @(negedge clk);
    if (reset && mem_en && ((mem_we ? stall_wr : stall_rd) > 0)) begin
      mem_gnt = 1'b0;
      if (snap_v) check("stall_hold", {mem_we, mem_addr, mem_wdata}, snap);
      snap   = {mem_we, mem_addr, mem_wdata};
      snap_v = 1'b1;
      if (mem_we) stall_wr--; else stall_rd--;
    end else begin
      mem_gnt = 1'b1;
      snap_v  = 1'b0;
    end
  end

  // ---------------- ready monitor ----------------
  always begin
    @(posedge clk);
    #1;
    if (reset && ready) begin
      if (exp_q.size() == 0) check("unexpected_ready", 1, 0);
      else check("ready_data_in", data_in, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // Latency n counts edges from the one that first sees the request to the
  // one after which ready is visible: read RD_LAT+2, write 2, plus stalls.
  task automatic rd_phase(input logic [63:0] addr, input logic [63:0] exp_data,
                          input int exp_cycles);
    int n = 0;
    exp_q.push_back(exp_data);
    @(negedge clk);
    req = 1'b1; write = 1'b0; address = addr;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready && n < 50);
    check("rd_latency", n, exp_cycles);
    last_rd = exp_data;
  endtask

  task automatic wr_phase(input logic [63:0] data, input logic [AW-1:0] waddr,
                          input int exp_cycles);
    int n = 0;
    exp_q.push_back(last_rd);
    wr_q.push_back({waddr, data});
    @(negedge clk);           // still RD_RESP
    @(negedge clk);           // WR_WAIT
    write = 1'b1; dout = data;
    do begin
      @(posedge clk); #1; n++;
    end while (!ready && n < 50);
    check("wr_latency", n, exp_cycles);
    req = 1'b0; write = 1'b0;
    exp_cnt = next_cnt(exp_cnt);
    @(posedge clk); #1;
    check("upd_count", upd_count, exp_cnt);
    check("idle_after_wr", dbg_state, IDLE);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"},     ready,     0);
    check({tag, "_mem_en"},    mem_en,    0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_addr_err"},  addr_err,  0);
    check({tag, "_data_in"},   data_in,   0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_upd_count"}, upd_count, 0);
    check({tag, "_state"},     dbg_state, IDLE);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; req = 1'b0; write = 1'b0; address = '0; dout = '0;
    mem_gnt = 1'b1; mem_rdata = '0;
    mem_model[16'd8]  = 64'd5;
    mem_model[16'd17] = 64'hA5A5_0000_1234_5678;
    mem_model[16'd32] = 64'd7;
    mem_model[16'd1]  = 64'h33;
    mem_model[16'd3]  = 64'h99;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Single RMW at byte 0x40 -> word 8
    rd_phase(64'h40, 64'd5, RD_LAT + 2);
    wr_phase(64'd6, 16'd8, 2);

    // Four-cycle grant stall in each phase
    stall_rd = 4;
    rd_phase(64'h88, 64'hA5A5_0000_1234_5678, RD_LAT + 2 + 4);
    stall_wr = 4;
    wr_phase(64'hA5A5_0000_1234_5679, 16'd17, 2 + 4);

    // Abandoned RMW: req dropped in WR_WAIT
    rd_phase(64'h100, 64'd7, RD_LAT + 2);
    @(negedge clk); @(negedge clk);
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abandon_state", dbg_state, IDLE);
    check("abandon_mem_en", mem_en, 0);
    check("abandon_count", upd_count, exp_cnt);

    // Write phase presented in IDLE is ignored
    @(negedge clk);
    req = 1'b1; write = 1'b1; address = 64'h40; dout = 64'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    check("ignored_wr_state", dbg_state, IDLE);
    check("ignored_wr_mem_en", mem_en, 0);
    @(negedge clk); req = 1'b0; write = 1'b0;

    // Out-of-range address wraps and sets the sticky error
    rd_phase(64'h1_0000_0008, 64'h33, RD_LAT + 2);
    check("wrap_mem_addr", mem_addr, 16'd1);
    check("wrap_addr_err", addr_err, 1);
    wr_phase(64'h34, 16'd1, 2);
    rd_phase(64'h18, 64'h99, RD_LAT + 2);
    wr_phase(64'h9A, 16'd3, 2);
    check("addr_err_sticky", addr_err, 1);

    // Asynchronous reset while in RD_WAIT
    @(negedge clk);
    req = 1'b1; write = 1'b0; address = 64'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_state", dbg_state, RD_WAIT);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    exp_cnt = '0; last_rd = '0;
    @(negedge clk);

    // Fresh RMW after reset (word 8 now holds 6)
    rd_phase(64'h40, 64'd6, RD_LAT + 2);
    wr_phase(64'd7, 16'd8, 2);
    check("post_reset_addr_err", addr_err, 0);

    // Misaligned byte address: low bits drop, error flagged
    rd_phase(64'h43, 64'd7, RD_LAT + 2);
    check("misalign_mem_addr", mem_addr, 16'd8);
    check("misalign_addr_err", addr_err, 1);
    wr_phase(64'd8, 16'd8, 2);

    // Counter saturation
`ifdef GUPS_STATS_EN
    @(negedge clk);
    force dut.upd_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.upd_count_q;
    exp_cnt = 32'hFFFF_FFFD;
`endif
    for (int i = 0; i < 3; i++) begin
      rd_phase(64'h40, 64'd8 + 64'(i), RD_LAT + 2);
      wr_phase(64'd9 + 64'(i), 16'd8, 2);
    end
`ifdef GUPS_STATS_EN
    check("saturated_count", upd_count, 32'hFFFF_FFFF);
`else
    check("stats_off_count", upd_count, 32'd0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
